// File: rtl/scc_pkg.sv
// Shared definitions for the SCC register block: register offsets, wave-access
// state encoding and the latched SRAM request payload.
package scc_pkg;

  localparam int unsigned MAX_CHANNELS = 8;

  localparam logic [7:0] FREQ_BASE  = 8'h00;
  localparam logic [7:0] VOL_BASE   = 8'h40;
  localparam logic [7:0] ENABLE_REG = 8'h60;
  localparam logic [7:0] MODE_REG   = 8'h70;
  localparam logic [7:0] WAVE_BASE  = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic       we;
    logic [2:0] id;
    logic [4:0] a;
    logic [7:0] d;
  } wave_req_t;

endpackage

// File: rtl/scc_wave_access.sv
// Sequences one host access to the shared wave SRAM over a req/ack handshake
// and reports busy while the access is outstanding.
module scc_wave_access
  import scc_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  wave_req_t  req,
  input  logic       sram_ack,
  input  logic [7:0] sram_q,
  output logic       busy,
  output logic       sram_req,
  output wave_req_t  sram_cmd,
  output logic       resp_valid_c,
  output logic [7:0] resp_data
);

  state_t state, state_next;
  logic   load, capture;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = REQ;
          load       = 1'b1;
        end
      end
      REQ: begin
        if (sram_ack) begin
          state_next = sram_cmd.we ? IDLE : RESP;
          capture    = ~sram_cmd.we;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy and sram_req are flopped from the next state so they track it exactly
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      sram_req  <= 1'b0;
      sram_cmd  <= '0;
      resp_data <= '0;
    end else begin
      state    <= state_next;
      busy     <= (state_next != IDLE);
      sram_req <= (state_next == REQ);
      if (load) sram_cmd <= req;
      if (capture) resp_data <= sram_q;
    end
  end

  assign resp_valid_c = (state == RESP);

endmodule

// File: rtl/scc_register_multi.sv
// SCC control registers for CHANNELS wave-table channels with shadowed frequency
// commit, a registered parameter lookup port and a sequenced wave SRAM path.
module scc_register_multi
  import scc_pkg::*;
#(
  parameter  int unsigned CHANNELS  = 5,
  parameter  int unsigned FREQ_BITS = 12,
  parameter  int unsigned VOL_BITS  = 4,
  localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 wrreq,
  input  logic                 rdreq,
  input  logic [7:0]           address,
  input  logic [7:0]           wrdata,
  output logic [7:0]           rddata,
  output logic                 rdvalid,
  output logic                 busy,
  output logic                 sram_req,
  output logic                 sram_we,
  output logic [2:0]           sram_id,
  output logic [4:0]           sram_a,
  output logic [7:0]           sram_d,
  input  logic                 sram_ack,
  input  logic [7:0]           sram_q,
  input  logic [CH_W-1:0]      active,
  output logic [FREQ_BITS-1:0] par_freq,
  output logic [VOL_BITS-1:0]  par_vol,
  output logic                 par_en,
  output logic [CHANNELS-1:0]  clear_counter,
  output logic                 wave_reset
);

  localparam int unsigned HI_W    = FREQ_BITS - 8;
  localparam logic [7:0]  CH_MASK = 8'((16'(1) << CHANNELS) - 16'(1));

  logic [FREQ_BITS-1:0] freq   [MAX_CHANNELS];
  logic [7:0]           shadow [MAX_CHANNELS];
  logic [VOL_BITS-1:0]  vol    [MAX_CHANNELS];
  logic [7:0]           enable;
  logic                 atomic;

  logic       is_freq, is_vol, freq_ok, vol_ok;
  logic [2:0] ch_f, ch_v;
  logic       wr_en, rd_en, freq_commit;
  logic [7:0] rd_mux;
  logic [2:0] act_idx;
  logic       act_ok;

  wave_req_t  wave_req, sram_cmd;
  logic       resp_valid_c;
  logic [7:0] resp_data;

  assign is_freq = (address[7:4] == FREQ_BASE[7:4]);
  assign is_vol  = (address[7:3] == VOL_BASE[7:3]);
  assign ch_f    = address[3:1];
  assign ch_v    = address[2:0];
  assign freq_ok = is_freq && (32'(ch_f) < CHANNELS);
  assign vol_ok  = is_vol && (32'(ch_v) < CHANNELS);

  // Register-space strobes are dropped while a wave access is outstanding
  assign wr_en       = wrreq & ~busy & ~address[7];
  assign rd_en       = rdreq & ~wrreq & ~busy & ~address[7];
  assign freq_commit = wr_en & freq_ok & (address[0] | ~atomic);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int i = 0; i < MAX_CHANNELS; i++) begin
        freq[i]   <= '0;
        shadow[i] <= '0;
        vol[i]    <= '0;
      end
      enable        <= '0;
      atomic        <= 1'b0;
      wave_reset    <= 1'b0;
      clear_counter <= '0;
    end else begin
      clear_counter <= freq_commit ? (CHANNELS'(1) << ch_f) : '0;
      if (wr_en && freq_ok) begin
        if (!address[0]) begin
          shadow[ch_f] <= wrdata;
          if (!atomic) freq[ch_f][7:0] <= wrdata;
        end else begin
          freq[ch_f] <= {wrdata[HI_W-1:0], atomic ? shadow[ch_f] : freq[ch_f][7:0]};
        end
      end
      if (wr_en && vol_ok) vol[ch_v] <= wrdata[VOL_BITS-1:0];
      if (wr_en && address == ENABLE_REG) enable <= wrdata & CH_MASK;
      if (wr_en && address == MODE_REG) begin
        atomic     <= wrdata[0];
        wave_reset <= wrdata[5];
      end
    end
  end

  // Absent channels read 0x00, holes in the map read 0xFF
  always_comb begin
    rd_mux = 8'hFF;
    if (is_freq) begin
      rd_mux = 8'h00;
      if (freq_ok) rd_mux = address[0] ? 8'(freq[ch_f] >> 8) : freq[ch_f][7:0];
    end else if (is_vol) begin
      rd_mux = vol_ok ? 8'(vol[ch_v]) : 8'h00;
    end else if (address == ENABLE_REG) begin
      rd_mux = enable;
    end else if (address == MODE_REG) begin
      rd_mux = {2'b00, wave_reset, 4'b0000, atomic};
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      rddata  <= 8'h00;
      rdvalid <= 1'b0;
    end else begin
      rdvalid <= rd_en | resp_valid_c;
      if (resp_valid_c) rddata <= resp_data;
      else if (rd_en) rddata <= rd_mux;
    end
  end

  assign act_idx = 3'(active);
  assign act_ok  = (32'(active) < CHANNELS);

  always_ff @(posedge clk) begin
    if (!nreset || !act_ok) begin
      par_freq <= '0;
      par_vol  <= '0;
      par_en   <= 1'b0;
    end else begin
      par_freq <= freq[act_idx];
      par_vol  <= vol[act_idx];
      par_en   <= enable[act_idx];
    end
  end

  assign wave_req = '{we: wrreq, id: address[7:5], a: address[4:0], d: wrdata};

  scc_wave_access u_wave (
    .clk          (clk),
    .nreset       (nreset),
    .start        ((wrreq | rdreq) & address[7]),
    .req          (wave_req),
    .sram_ack     (sram_ack),
    .sram_q       (sram_q),
    .busy         (busy),
    .sram_req     (sram_req),
    .sram_cmd     (sram_cmd),
    .resp_valid_c (resp_valid_c),
    .resp_data    (resp_data)
  );

  assign sram_we = sram_cmd.we;
  assign sram_id = sram_cmd.id;
  assign sram_a  = sram_cmd.a;
  assign sram_d  = sram_cmd.d;

endmodule

// File: tb/tb_scc_register_multi.sv
// Randomised scoreboard bench for scc_register_multi with an arithmetic
// register-map model and a behavioural SRAM responder.
module tb_scc_register_multi;

  localparam int unsigned CHANNELS  = 5;
  localparam int unsigned FREQ_BITS = 12;
  localparam int unsigned VOL_BITS  = 4;
  localparam int unsigned CH_W      = 3;

  logic                 clk, nreset, wrreq, rdreq;
  logic [7:0]           address, wrdata, rddata;
  logic                 rdvalid, busy, sram_req, sram_we, sram_ack;
  logic [2:0]           sram_id;
  logic [4:0]           sram_a;
  logic [7:0]           sram_d, sram_q;
  logic [CH_W-1:0]      active;
  logic [FREQ_BITS-1:0] par_freq;
  logic [VOL_BITS-1:0]  par_vol;
  logic                 par_en;
  logic [CHANNELS-1:0]  clear_counter;
  logic                 wave_reset;

  scc_register_multi #(.CHANNELS(CHANNELS), .FREQ_BITS(FREQ_BITS), .VOL_BITS(VOL_BITS)) dut (
    .clk(clk), .nreset(nreset), .wrreq(wrreq), .rdreq(rdreq), .address(address),
    .wrdata(wrdata), .rddata(rddata), .rdvalid(rdvalid), .busy(busy),
    .sram_req(sram_req), .sram_we(sram_we), .sram_id(sram_id), .sram_a(sram_a),
    .sram_d(sram_d), .sram_ack(sram_ack), .sram_q(sram_q), .active(active),
    .par_freq(par_freq), .par_vol(par_vol), .par_en(par_en),
    .clear_counter(clear_counter), .wave_reset(wave_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit we;
    int id;
    int a;
    int d;
  } sreq_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         freq_m[8], shadow_m[8], vol_m[8];
  int         en_m, atomic_m, wrst_m;
  logic [7:0] wave_mem[256];
  sreq_t      exp_req_q[$];
  int         exp_rd_q[$];
  int         ack_delay = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      freq_m[i] = 0; shadow_m[i] = 0; vol_m[i] = 0;
    end
    en_m = 0; atomic_m = 0; wrst_m = 0;
  endfunction

  // Returns the clear_counter mask the write should produce
  function automatic int model_write(input int addr, input int data);
    int c;
    if (addr < 16) begin
      c = addr / 2;
      if (c >= CHANNELS) return 0;
      if (addr % 2 == 1) begin
        freq_m[c] = (data % (1 << (FREQ_BITS - 8))) * 256 +
                    (atomic_m != 0 ? shadow_m[c] : freq_m[c] % 256);
        return 1 << c;
      end
      shadow_m[c] = data;
      if (atomic_m == 0) begin
        freq_m[c] = (freq_m[c] / 256) * 256 + data;
        return 1 << c;
      end
    end else if (addr >= 'h40 && addr < 'h48) begin
      c = addr - 'h40;
      if (c < CHANNELS) vol_m[c] = data % (1 << VOL_BITS);
    end else if (addr == 'h60) begin
      en_m = data % (1 << CHANNELS);
    end else if (addr == 'h70) begin
      atomic_m = data % 2;
      wrst_m   = (data / 32) % 2;
    end
    return 0;
  endfunction

  function automatic int model_read(input int addr);
    int c;
    if (addr < 16) begin
      c = addr / 2;
      if (c >= CHANNELS) return 0;
      return (addr % 2 == 1) ? freq_m[c] / 256 : freq_m[c] % 256;
    end
    if (addr >= 'h40 && addr < 'h48) return (addr - 'h40 < CHANNELS) ? vol_m[addr - 'h40] : 0;
    if (addr == 'h60) return en_m;
    if (addr == 'h70) return wrst_m * 32 + atomic_m;
    return 'hFF;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit wr, input bit rd, input int addr, input int data);
    wrreq = wr; rdreq = rd; address = 8'(addr); wrdata = 8'(data);
    cyc();
    wrreq = 1'b0; rdreq = 1'b0;
  endtask

  task automatic check_par();
    int a;
    a = int'(active);
    check("par_freq", int'(par_freq), a < CHANNELS ? freq_m[a] : 0);
    check("par_vol", int'(par_vol), a < CHANNELS ? vol_m[a] : 0);
    check("par_en", int'(par_en), a < CHANNELS ? (en_m >> a) % 2 : 0);
  endtask

  task automatic reg_wr(input int addr, input int data, input bit also_rd);
    int m;
    strobe(1'b1, also_rd, addr, data);
    m = model_write(addr, data);
    check("clear_counter", int'(clear_counter), m);
    check("wave_reset", int'(wave_reset), wrst_m);
    check("busy_reg", int'(busy), 0);
    active = CH_W'($urandom_range(0, 7));
    cyc();
    check("clear_counter_idle", int'(clear_counter), 0);
    check_par();
  endtask

  task automatic reg_rd(input int addr);
    exp_rd_q.push_back(model_read(addr));
    strobe(1'b0, 1'b1, addr, 0);
    cyc();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      cyc();
      n++;
    end
    check("busy_release", int'(busy), 0);
    cyc();
  endtask

  task automatic wave_op(input bit wr, input int addr, input int data, input int dly, input bit poke);
    ack_delay = dly;
    exp_req_q.push_back('{we: wr, id: addr / 32, a: addr % 32, d: data});
    if (!wr) exp_rd_q.push_back(int'(wave_mem[addr]));
    strobe(wr, wr ? 1'($urandom_range(0, 1)) : 1'b1, addr, data);
    check("busy_wave", int'(busy), 1);
    if (poke) strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 255));
    wait_idle();
  endtask

  // Read-data scoreboard monitor
  initial begin
    int e;
    forever begin
      cyc();
      if (rdvalid) begin
        if (exp_rd_q.size() == 0) begin
          check("rdvalid_unexpected", int'(rdvalid), 0);
        end else begin
          e = exp_rd_q.pop_front();
          check("rddata", int'(rddata), e);
        end
      end
    end
  end

  // SRAM responder: checks request fields, acks after ack_delay cycles
  initial begin
    sreq_t r;
    bit    aborted;
    sram_ack = 1'b0;
    sram_q   = 8'h00;
    forever begin
      cyc();
      sram_q = 8'($urandom);
      if (sram_req) begin
        if (exp_req_q.size() == 0) begin
          check("sram_req_unexpected", int'(sram_req), 0);
          r = '{we: sram_we, id: int'(sram_id), a: int'(sram_a), d: int'(sram_d)};
        end else begin
          r = exp_req_q.pop_front();
          check("sram_we", int'(sram_we), int'(r.we));
          check("sram_id", int'(sram_id), r.id);
          check("sram_a", int'(sram_a), r.a);
          check("sram_d", int'(sram_d), r.d);
        end
        aborted = 1'b0;
        for (int k = 0; k < ack_delay; k++) begin
          cyc();
          sram_q = 8'($urandom);
          if (!sram_req) begin
            aborted = 1'b1;
            break;
          end
          check("sram_hold_we", int'(sram_we), int'(r.we));
          check("sram_hold_addr", int'(sram_id) * 32 + int'(sram_a), r.id * 32 + r.a);
          check("sram_hold_d", int'(sram_d), r.d);
        end
        sram_ack = 1'b1;
        if (!r.we) sram_q = wave_mem[r.id * 32 + r.a];
        if (!aborted && r.we) wave_mem[r.id * 32 + r.a] = 8'(r.d);
        cyc();
        sram_ack = 1'b0;
        sram_q   = 8'($urandom);
        check("sram_req_after_ack", int'(sram_req), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n, op, addr;
    for (int i = 0; i < 256; i++) wave_mem[i] = 8'($urandom);
    nreset = 1'b0; wrreq = 1'b0; rdreq = 1'b0; address = 8'h00; wrdata = 8'h00;
    active = '0;
    model_reset();
    cyc(); cyc();
    check("rst_rddata", int'(rddata), 0);
    check("rst_rdvalid", int'(rdvalid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sram_req", int'(sram_req), 0);
    check("rst_sram_we", int'(sram_we), 0);
    check("rst_clear", int'(clear_counter), 0);
    check("rst_wave_reset", int'(wave_reset), 0);
    check_par();
    nreset = 1'b1;
    cyc();

    // Atomic frequency commit
    reg_wr('h70, 'h01, 1'b0);
    reg_wr('h00, 'h34, 1'b0);
    reg_rd('h00);
    reg_wr('h01, 'h12, 1'b0);
    active = 3'd0;
    cyc();
    check("atomic_freq0", int'(par_freq), 'h234);
    reg_rd('h01);

    // Direct low-byte update
    reg_wr('h70, 'h00, 1'b0);
    reg_wr('h02, 'hAB, 1'b0);
    active = 3'd1;
    cyc();
    check("direct_freq1_lo", int'(par_freq) % 256, 'hAB);
    reg_rd('h02);

    // Wave write held for 4 request cycles; register write during busy dropped
    ack_delay = 3;
    exp_req_q.push_back('{we: 1'b1, id: 4, a: 5, d: 'h5A});
    strobe(1'b1, 1'b0, 'h85, 'h5A);
    n = 0;
    while (sram_req && n < 20) begin
      n++;
      if (n == 2) begin
        wrreq = 1'b1; address = 8'h40; wrdata = 8'h0F;
      end
      cyc();
      wrreq = 1'b0;
    end
    check("wave_wr_req_cycles", n, 4);
    wait_idle();
    exp_rd_q.push_back(0);
    strobe(1'b0, 1'b1, 'h40, 0);
    cyc();

    // Wave read minimum latency
    wave_mem['hA0] = 8'hC3;
    ack_delay = 0;
    exp_req_q.push_back('{we: 1'b0, id: 5, a: 0, d: 'h11});
    exp_rd_q.push_back('hC3);
    rdreq = 1'b1; address = 8'hA0; wrdata = 8'h11;
    cyc();
    rdreq = 1'b0;
    n = 1;
    while (!rdvalid && n < 20) begin
      cyc();
      n++;
    end
    check("wave_rd_latency", n, 3);
    wait_idle();

    // Lookup port
    reg_wr('h60, 'h1F, 1'b0);
    reg_wr('h44, 'h09, 1'b0);
    active = 3'd4;
    cyc();
    check("lookup_en4", int'(par_en), 1);
    check("lookup_vol4", int'(par_vol), 9);
    active = 3'd7;
    cyc();
    check("lookup_oob_freq", int'(par_freq), 0);
    check("lookup_oob_vol", int'(par_vol), 0);
    check("lookup_oob_en", int'(par_en), 0);

    // Randomised traffic
    for (int it = 0; it < 250; it++) begin
      op = $urandom_range(0, 9);
      case ($urandom_range(0, 4))
        0, 1:    addr = $urandom_range(0, 15);
        2:       addr = 'h40 + $urandom_range(0, 7);
        3:       addr = ($urandom_range(0, 1) != 0) ? 'h60 : 'h70;
        default: addr = $urandom_range(0, 127);
      endcase
      if (op <= 3)      reg_wr(addr, $urandom_range(0, 255), 1'b0);
      else if (op <= 5) reg_rd(addr);
      else if (op == 6) reg_wr(addr, $urandom_range(0, 255), 1'b1);
      else wave_op(op == 7, $urandom_range(128, 255), $urandom_range(0, 255),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a request abandons it; the late ack is ignored
    ack_delay = 8;
    exp_req_q.push_back('{we: 1'b1, id: 4, a: 16, d: 'h77});
    strobe(1'b1, 1'b0, 'h90, 'h77);
    cyc();
    nreset = 1'b0;
    cyc();
    nreset = 1'b1;
    model_reset();
    check("abort_sram_req", int'(sram_req), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_rddata", int'(rddata), 0);
    cyc(); cyc(); cyc();
    check("late_ack_sram_req", int'(sram_req), 0);
    check("late_ack_busy", int'(busy), 0);
    reg_rd('h70);

    repeat (5) cyc();
    check("rd_queue_drained", exp_rd_q.size(), 0);
    check("req_queue_drained", exp_req_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scc_register_multi.md
Name: scc_register_multi

Overview:
- Parametrised successor of the SCC register file: control registers for CHANNELS wave-table channels plus a sequenced access path to the shared wave SRAM.
- Sits between the cartridge bus decoder, which supplies a local 8-bit register offset, and the tone generators.
- Adds over the previous generation: configurable channel count and field widths, atomic (shadowed) frequency update, a req/ack SRAM handshake with a busy flag, and a registered per-channel parameter lookup port.

Parameters:
- CHANNELS, 5, number of channels; legal range 1..8.
- FREQ_BITS, 12, frequency counter width; legal range 9..16.
- VOL_BITS, 4, volume width; legal range 1..8.
- Local constant CH_W = clog2(CHANNELS), minimum 1.

Ports:
- clk  in  1  system clock.
- nreset  in  1  reset. Synchronous, active-low; takes effect on the clk edge only.
- wrreq  in  1  single-cycle host write strobe.
- rdreq  in  1  single-cycle host read strobe.
- address  in  8  local register offset.
- wrdata  in  8  write data.
- rddata  out  8  read data. Valid while rdvalid=1; holds its value otherwise.
- rdvalid  out  1  one-cycle pulse when rddata is updated.
- busy  out  1  high while an SRAM access is pending; host strobes are ignored while high.
- sram_req  out  1  SRAM request. Held high until acknowledged.
- sram_we  out  1  1 = write, 0 = read. Stable while sram_req=1.
- sram_id  out  3  channel select for the SRAM access.
- sram_a  out  5  byte index within the channel's wave.
- sram_d  out  8  SRAM write data.
- sram_ack  in  1  SRAM acknowledge. On a read, sram_q is valid in the same cycle.
- sram_q  in  8  SRAM read data.
- active  in  CH_W  channel index for the parameter lookup port.
- par_freq  out  FREQ_BITS  frequency of the channel selected by active, registered.
- par_vol  out  VOL_BITS  volume of that channel, registered.
- par_en  out  1  enable of that channel, registered.
- clear_counter  out  CHANNELS  one-cycle per-channel pulse on frequency commit.
- wave_reset  out  1  mode register bit 5.

Behaviour:
- Register map (by address):
  - 0x00+2c: frequency low byte of channel c, written into a shadow register.
  - 0x01+2c: frequency high byte of channel c, using bits [FREQ_BITS-9:0].
  - 0x40+c: volume of channel c, using wrdata[VOL_BITS-1:0].
  - 0x60: enable mask; bit c enables channel c.
  - 0x70: mode register. Bit0 = atomic, bit5 = wave_reset.
  - 0x80-0xFF: wave RAM. sram_id = address[7:5], sram_a = address[4:0].
  - Channel indices c >= CHANNELS: writes ignored, reads return 0x00.
  - Any other unmapped offset: reads return 0xFF.
- Frequency update, atomic=0: a low-byte write updates freq[7:0] directly; a high-byte write updates the upper bits. Either write pulses clear_counter[c] in the cycle after the write.
- Frequency update, atomic=1: a low-byte write goes to the shadow only. A high-byte write commits {high, shadow} to freq in one cycle and pulses clear_counter[c]. A second low-byte write before the commit overwrites the shadow.
- Register reads: rddata and rdvalid appear 1 cycle after rdreq. busy is not asserted.
- Wave access state machine: IDLE -> REQ -> (read only) RESP -> IDLE.
  - IDLE: a wrreq/rdreq at offset >= 0x80 latches id, a, d and we, then moves to REQ; busy=1 from the next cycle.
  - REQ: sram_req=1 with all fields stable. When sram_ack=1: a write returns to IDLE; a read captures sram_q and moves to RESP.
  - RESP: rddata=captured value, rdvalid=1 for one cycle, then IDLE with busy=0.
  - Minimum latency: write = 2 cycles, read = 3 cycles.
- Simultaneous wrreq and rdreq: the write is performed and the read is dropped.
- Strobes while busy=1: dropped with no side effects. This applies to register offsets as well.
- Wave writes to channel ids >= CHANNELS: still forwarded to the SRAM (the SRAM owns decoding).
- Lookup port: par_* reflect the registers at active one cycle later. A same-cycle register write is visible one cycle after that, i.e. 2 cycles after the write. active >= CHANNELS gives all outputs 0.
- Reset (nreset=0 at a clk edge):
  - All frequency, volume, shadow, enable and mode registers = 0.
  - rddata=0x00; rdvalid, busy, sram_req, sram_we, clear_counter, wave_reset and par_* = 0.
  - State machine returns to IDLE.
  - Reset during REQ abandons the access; a late sram_ack is ignored.

Decomposition:
- Shared package scc_pkg holds:
  - The register-offset constants: FREQ_BASE, VOL_BASE, ENABLE_REG, MODE_REG, WAVE_BASE.
  - The state encoding enum (IDLE/REQ/RESP).
  - MAX_CHANNELS=8.
- One natural sub-module, scc_wave_access: the state machine, request latches and busy generation.

Test Plan:
- Reset, then write 0x70=0x01, 0x00=0x34, 0x01=0x12 -> freq0 unchanged after the low write; becomes 0x234 when FREQ_BITS=12 (upper bits masked); clear_counter[0] pulses once, one cycle after the high write.
- atomic=0: write 0x02=0xAB -> freq1[7:0]=0xAB next cycle; clear_counter[1] pulses.
- Wave write 0x85=0x5A with sram_ack delayed 3 cycles -> sram_req high for 4 cycles with id=4, a=5, d=0x5A, we=1. A wrreq 0x40=0x0F issued while busy -> volume0 stays 0.
- Wave read 0xA0 with ack=1 after 1 cycle and sram_q=0xC3 -> rdvalid pulses with rddata=0xC3 exactly 3 cycles after rdreq.
- Write 0x60=0x1F, 0x44=0x09, then set active=4 -> par_en=1 and par_vol=9 one cycle later. Set active=7 with CHANNELS=5 -> all par_* = 0.
- Assert nreset=0 while in REQ, then raise sram_ack -> sram_req=0 and busy=0. A following register read of 0x70 returns 0x00.
